// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each requester owns a registered response slot with its own valid/ready handshake.
module alu_share_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [2:0]        req0_func3,
    input  logic              req0_subsra,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [2:0]        req1_func3,
    input  logic              req1_subsra,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    output logic [2:0]        alu_func3,
    output logic              alu_subsra,
    input  logic [DATA_W-1:0] alu_result,
    output logic [CNT_W-1:0]  contention_cnt
);

    logic              resp0_valid_q, resp0_valid_d;
    logic              resp1_valid_q, resp1_valid_d;
    logic [DATA_W-1:0] resp0_result_q, resp0_result_d;
    logic [DATA_W-1:0] resp1_result_q, resp1_result_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              elig0, elig1, grant0, grant1;

    // A full slot may still win if it drains in the same cycle.
    always_comb begin
        elig0  = req0_valid && (!resp0_valid_q || resp0_ready);
        elig1  = req1_valid && (!resp1_valid_q || resp1_ready);
        grant0 = elig0 && (!elig1 || last_grant_q);
        grant1 = elig1 && (!elig0 || !last_grant_q);
    end

    always_comb begin
        alu_operand1 = '0;
        alu_operand2 = '0;
        alu_func3    = 3'b000;
        alu_subsra   = 1'b0;
        if (grant0) begin
            alu_operand1 = req0_op1;
            alu_operand2 = req0_op2;
            alu_func3    = req0_func3;
            alu_subsra   = req0_subsra;
        end else if (grant1) begin
            alu_operand1 = req1_op1;
            alu_operand2 = req1_op2;
            alu_func3    = req1_func3;
            alu_subsra   = req1_subsra;
        end
    end

    always_comb begin
        resp0_valid_d  = resp0_valid_q;
        resp1_valid_d  = resp1_valid_q;
        resp0_result_d = resp0_result_q;
        resp1_result_d = resp1_result_q;
        last_grant_d   = last_grant_q;
        cnt_d          = cnt_q;
        if (resp0_ready) resp0_valid_d = 1'b0;
        if (resp1_ready) resp1_valid_d = 1'b0;
        if (grant0) begin
            resp0_valid_d  = 1'b1;
            resp0_result_d = alu_result;
            last_grant_d   = 1'b0;
        end
        if (grant1) begin
            resp1_valid_d  = 1'b1;
            resp1_result_d = alu_result;
            last_grant_d   = 1'b1;
        end
        if (elig0 && elig1 && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp0_valid_q  <= 1'b0;
            resp1_valid_q  <= 1'b0;
            resp0_result_q <= '0;
            resp1_result_q <= '0;
            last_grant_q   <= 1'b1;
            cnt_q          <= '0;
        end else begin
            resp0_valid_q  <= resp0_valid_d;
            resp1_valid_q  <= resp1_valid_d;
            resp0_result_q <= resp0_result_d;
            resp1_result_q <= resp1_result_d;
            last_grant_q   <= last_grant_d;
            cnt_q          <= cnt_d;
        end
    end

    assign req0_ready     = grant0;
    assign req1_ready     = grant1;
    assign resp0_valid    = resp0_valid_q;
    assign resp1_valid    = resp1_valid_q;
    assign resp0_result   = resp0_result_q;
    assign resp1_result   = resp1_result_q;
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: table-driven cycles with a result scoreboard per requester.
module tb_alu_share_arbiter;

    typedef struct packed {
        logic [2:0]  f3;
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct packed {
        logic v0;
        op_t  op0;
        logic v1;
        op_t  op1;
        logic rr0;
        logic rr1;
        logic g0;
        logic g1;
        logic cont;
    } row_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [2:0]  req0_func3 = '0, req1_func3 = '0;
    logic        req0_subsra = 1'b0, req1_subsra = 1'b0;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
    logic [31:0] resp0_result, resp1_result;
    logic [31:0] alu_operand1, alu_operand2, alu_result;
    logic [2:0]  alu_func3;
    logic        alu_subsra;
    logic [15:0] contention_cnt;

    logic        s_req0_ready, s_req1_ready, s_resp0_valid, s_resp1_valid;
    logic [31:0] s_resp0_result, s_resp1_result;
    logic [31:0] s_alu_operand1, s_alu_operand2, s_alu_result;
    logic [2:0]  s_alu_func3;
    logic        s_alu_subsra;
    logic [3:0]  s_contention_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_cnt = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    row_t        rows[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input op_t o);
        case (o.f3)
            3'd0:    ref_alu = o.sub ? o.a - o.b : o.a + o.b;
            3'd1:    ref_alu = o.a << o.b[4:0];
            3'd2:    ref_alu = {31'd0, $signed(o.a) < $signed(o.b)};
            3'd3:    ref_alu = {31'd0, o.a < o.b};
            3'd4:    ref_alu = o.a ^ o.b;
            3'd5:    ref_alu = o.sub ? 32'($signed(o.a) >>> o.b[4:0]) : o.a >> o.b[4:0];
            3'd6:    ref_alu = o.a | o.b;
            default: ref_alu = o.a & o.b;
        endcase
    endfunction

    always_comb alu_result   = ref_alu('{alu_func3, alu_subsra, alu_operand1, alu_operand2});
    always_comb s_alu_result = ref_alu('{s_alu_func3, s_alu_subsra, s_alu_operand1, s_alu_operand2});

    alu_share_arbiter #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req0_func3(req0_func3), .req0_subsra(req0_subsra),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .req1_func3(req1_func3), .req1_subsra(req1_subsra),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_func3(alu_func3),
        .alu_subsra(alu_subsra), .alu_result(alu_result), .contention_cnt(contention_cnt)
    );

    alu_share_arbiter #(.DATA_W(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req0_func3(req0_func3), .req0_subsra(req0_subsra),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .req1_func3(req1_func3), .req1_subsra(req1_subsra),
        .resp0_valid(s_resp0_valid), .resp0_ready(resp0_ready), .resp0_result(s_resp0_result),
        .resp1_valid(s_resp1_valid), .resp1_ready(resp1_ready), .resp1_result(s_resp1_result),
        .alu_operand1(s_alu_operand1), .alu_operand2(s_alu_operand2), .alu_func3(s_alu_func3),
        .alu_subsra(s_alu_subsra), .alu_result(s_alu_result), .contention_cnt(s_contention_cnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk_op(input logic [2:0] f3, input logic sub,
                                  input logic [31:0] a, input logic [31:0] b);
        mk_op = '{f3, sub, a, b};
    endfunction

    function automatic row_t mk_row(input logic v0, input op_t op0, input logic v1, input op_t op1,
                                    input logic rr0, input logic rr1,
                                    input logic g0, input logic g1, input logic cont);
        mk_row = '{v0, op0, v1, op1, rr0, rr1, g0, g1, cont};
    endfunction

    // One cycle: drive, check combinational grant/mux, update scoreboard, check registers after the edge.
    task automatic step(input row_t r);
        op_t win;
        req0_valid = r.v0; req0_op1 = r.op0.a; req0_op2 = r.op0.b;
        req0_func3 = r.op0.f3; req0_subsra = r.op0.sub;
        req1_valid = r.v1; req1_op1 = r.op1.a; req1_op2 = r.op1.b;
        req1_func3 = r.op1.f3; req1_subsra = r.op1.sub;
        resp0_ready = r.rr0; resp1_ready = r.rr1;
        #1;
        chk("req0_ready", 128'(req0_ready), 128'(r.g0));
        chk("req1_ready", 128'(req1_ready), 128'(r.g1));
        win = r.g0 ? r.op0 : (r.g1 ? r.op1 : '0);
        chk("alu_ports", 128'({alu_func3, alu_subsra, alu_operand1, alu_operand2}), 128'(win));
        if (q0.size() > 0 && r.rr0) void'(q0.pop_front());
        if (q1.size() > 0 && r.rr1) void'(q1.pop_front());
        if (r.g0) q0.push_back(ref_alu(r.op0));
        if (r.g1) q1.push_back(ref_alu(r.op1));
        if (r.cont) exp_cnt++;
        @(posedge clk);
        #1;
        chk("resp0_valid", 128'(resp0_valid), 128'(q0.size() > 0));
        if (q0.size() > 0) chk("resp0_result", 128'(resp0_result), 128'(q0[0]));
        chk("resp1_valid", 128'(resp1_valid), 128'(q1.size() > 0));
        if (q1.size() > 0) chk("resp1_result", 128'(resp1_result), 128'(q1[0]));
        chk("contention_cnt", 128'(contention_cnt), 128'(exp_cnt));
        chk("contention_cnt_sat", 128'(s_contention_cnt), 128'(exp_cnt > 15 ? 15 : exp_cnt));
    endtask

    initial begin
        op_t nop, add57, sub35, and1, xor1, sra1, or1, sll1, addw, slt1, sltu1;
        nop   = '0;
        add57 = mk_op(3'd0, 1'b0, 32'd5, 32'd7);
        sub35 = mk_op(3'd0, 1'b1, 32'd3, 32'd5);
        and1  = mk_op(3'd7, 1'b0, 32'hFF00FF00, 32'h0FF00FF0);
        xor1  = mk_op(3'd4, 1'b0, 32'hF0F0F0F0, 32'hFFFFFFFF);
        sra1  = mk_op(3'd5, 1'b1, 32'h80000000, 32'd4);
        or1   = mk_op(3'd6, 1'b0, 32'h12340000, 32'h00005678);
        sll1  = mk_op(3'd1, 1'b0, 32'd1, 32'd31);
        addw  = mk_op(3'd0, 1'b0, 32'hFFFFFFFF, 32'd1);
        slt1  = mk_op(3'd2, 1'b0, 32'd1, 32'd2);
        sltu1 = mk_op(3'd3, 1'b0, 32'hFFFFFFFF, 32'd1);

        // Spot-check the reference ALU on the documented results.
        chk("ref_add", 128'(ref_alu(add57)), 128'(32'd12));
        chk("ref_sub", 128'(ref_alu(sub35)), 128'(32'hFFFFFFFE));
        chk("ref_xor", 128'(ref_alu(xor1)), 128'(32'h0F0F0F0F));
        chk("ref_sra", 128'(ref_alu(sra1)), 128'(32'hF8000000));

        // Phase A: single requester, back-to-back, then leave resp0 full.
        rows.push_back(mk_row(0, nop,   0, nop, 0, 0, 0, 0, 0));
        rows.push_back(mk_row(1, add57, 0, nop, 1, 0, 1, 0, 0));
        rows.push_back(mk_row(1, sub35, 0, nop, 1, 0, 1, 0, 0));
        rows.push_back(mk_row(1, and1,  0, nop, 1, 0, 1, 0, 0));
        // Phase B: ties, backpressure, blocked slot, drain.
        rows.push_back(mk_row(1, xor1,  1, sra1,  1, 1, 1, 0, 1));
        rows.push_back(mk_row(1, xor1,  1, sra1,  1, 1, 0, 1, 1));
        rows.push_back(mk_row(1, xor1,  1, sra1,  1, 1, 1, 0, 1));
        rows.push_back(mk_row(1, xor1,  1, sra1,  1, 1, 0, 1, 1));
        rows.push_back(mk_row(1, or1,   1, sll1,  1, 1, 1, 0, 1));
        rows.push_back(mk_row(1, addw,  0, nop,   0, 1, 0, 0, 0));
        rows.push_back(mk_row(1, addw,  0, nop,   0, 1, 0, 0, 0));
        rows.push_back(mk_row(1, addw,  0, nop,   1, 1, 1, 0, 0));
        rows.push_back(mk_row(1, slt1,  1, sltu1, 0, 1, 0, 1, 0));
        rows.push_back(mk_row(1, slt1,  1, sltu1, 0, 1, 0, 1, 0));
        rows.push_back(mk_row(1, slt1,  1, sltu1, 0, 1, 0, 1, 0));
        rows.push_back(mk_row(0, nop,   0, nop,   1, 1, 0, 0, 0));
        rows.push_back(mk_row(0, nop,   0, nop,   0, 0, 0, 0, 0));

        // Power-on reset with idle inputs.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 128'({req0_ready, req1_ready}), 128'(0));
        chk("rst_alu_idle", 128'({alu_func3, alu_subsra, alu_operand1, alu_operand2}), 128'(0));
        chk("rst_resp", 128'({resp0_valid, resp1_valid, resp0_result, resp1_result}), 128'(0));
        chk("rst_cnt", 128'(contention_cnt), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) step(rows[i]);

        // Mid-cycle asynchronous reset while resp0 holds a result.
        chk("pre_rst_resp0_valid", 128'(resp0_valid), 128'(1));
        #2;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        resp0_ready = 1'b0;
        #1;
        chk("async_rst_resp0_valid", 128'(resp0_valid), 128'(0));
        chk("async_rst_resp0_result", 128'(resp0_result), 128'(0));
        chk("async_rst_cnt", 128'(contention_cnt), 128'(0));
        chk("async_rst_alu_idle", 128'({alu_func3, alu_subsra, alu_operand1, alu_operand2}), 128'(0));
        q0.delete();
        q1.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 4; i < rows.size(); i++) step(rows[i]);

        // Long contention: strict alternation and counter saturation in the 4-bit instance.
        for (int i = 0; i < 20; i++) begin
            step(mk_row(1, mk_op(3'd0, 1'b0, 32'(i + 100), 32'd3), 1,
                        mk_op(3'd4, 1'b0, 32'(i), 32'hA5A5A5A5), 1, 1,
                        (i % 2) == 0, (i % 2) == 1, 1));
        end
        chk("sat_final", 128'(s_contention_cnt), 128'(4'd15));
        chk("cnt_final", 128'(contention_cnt), 128'(16'd25));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
